epd: RTL and testbench
======================

Name: epd

Overview:
- Ethernet packet detector on a byte-wide receive stream (one byte per clock, control=1 marks frame bytes, control=0 marks idle/IFG).
- Checks, in order:
  - preamble and SFD;
  - destination address;
  - source address;
  - type/length;
  - total frame size.
- Raises a registered flag for each field that passes.
- Counts valid frames in a 4-bit wrapping counter.
- Sits directly behind the MAC receive interface as a monitor; it never modifies or stalls the stream.

Parameters:
- MY_ADDR, 48'h010203040506, station address accepted as destination (broadcast FF:FF:FF:FF:FF:FF also accepted).
- MIN_FRAME, 64, minimum frame bytes, counted DST through last CRC byte.
- MAX_FRAME, 1518, maximum frame bytes, same counting.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- data  in  8  receive byte, sampled every rising edge.
- control  in  1  1 = frame byte, 0 = idle/IFG byte.
- preamble_valid  out  1  7×0x55 followed by 0xD5 received.
- dst_addr_valid  out  1  DST equals MY_ADDR or broadcast.
- src_addr_valid  out  1  SRC not all-zero and not broadcast.
- type_length_valid  out  1  type/length field legal.
- packet_size_valid  out  1  frame ended with size in [MIN_FRAME, MAX_FRAME] and all other flags set.
- valid_packet_counter  out  4  count of valid frames, wraps 15→0.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to HUNT; all flags and valid_packet_counter go to 0; byte counters go to 0.
  - Reset holds for as long as reset=0.
- All outputs are registered and update on the rising edge that samples the last byte of the field.
- FSM states: HUNT, PRE, DST, SRC, TYPE, BODY.
- HUNT:
  - control=1 and data=0x55 → PRE with pre_cnt=1, and all five flags clear.
  - Any other input → stay in HUNT.
  - Leading junk bytes with control=1 are ignored.
- PRE:
  - 0x55 with pre_cnt<7 → increment pre_cnt.
  - 0xD5 with pre_cnt==7 → set preamble_valid, go to DST.
  - Any other byte, extra 0x55, or control=0 → HUNT.
- DST:
  - Shift in 6 bytes, MSB byte first.
  - On the 6th byte, set dst_addr_valid if the address matches; go to SRC regardless of match.
- SRC:
  - 6 bytes.
  - On the 6th byte, set src_addr_valid if the address is not all-zero and not all-FF; go to TYPE.
- TYPE:
  - 2 bytes, big-endian.
  - Legal when value ≥ 0x0600 (EtherType) or ≤ 0x05DC (length); set type_length_valid if legal; go to BODY.
- Frame size counter:
  - 11 bits, saturating at 2047.
  - Counts every control=1 byte from the first DST byte onward.
- BODY:
  - Each control=1 byte increments size.
  - The first control=0 byte ends the frame:
    - set packet_size_valid if MIN_FRAME ≤ size ≤ MAX_FRAME and preamble, dst, src and type flags are all 1;
    - in the same edge, valid_packet_counter += 1;
    - go to HUNT.
- control=0 in DST, SRC or TYPE: abort, go to HUNT, no count. Flags already set keep their value until the next preamble start.
- IFG content: the data value during control=0 is not checked. A frame is terminated only by control=0. Bytes sent with control=1 after the CRC therefore extend the frame, including any following preamble and frame bytes, and are judged as one larger frame.
- Flags are levels: they hold from being set until the HUNT→PRE transition of the next frame, or until reset.
- Minimum IFG is one control=0 cycle. The edge after that cycle may start a new preamble.

Decomposition:
- Package epd_pkg holds:
  - state enum;
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - ETHERTYPE_MIN=16'h0600, LENGTH_MAX=16'h05DC;
  - BROADCAST=48'hFFFF_FFFF_FFFF.
- Single module; no sub-module is needed.

Test Plan:
- Golden frame with IFG between frames:
  - Stimulus: 7×55, D5, DST 01..06, SRC FF FE FD FC FB FA, type 08 00, 49×55 + FF (64-byte frame), then one control=0 byte.
  - Response: all five flags =1; counter=1.
- Counting and wrap:
  - Stimulus: four golden frames each separated by one control=0 byte, then 12 more.
  - Response: counter 1,2,3,4, then wraps to 0 after the 16th frame.
- Control-high IFG:
  - Stimulus: frame 2 followed by 3 bytes of 00 with control=1, then frame 3 and a control=0 byte.
  - Response: frames 2 and 3 merge into one 139-byte frame and count once; final count after frames 1–4 =3.
- Bad preamble:
  - Stimulus: 6×55 then D5.
  - Response: preamble_valid=0, FSM returns to HUNT, no count.
  - Stimulus: 55 after the 7th 55.
  - Response: same result.
- Field errors:
  - DST 01..07: dst_addr_valid=0, counter unchanged.
  - SRC all-zero: src_addr_valid=0.
  - type 0x0600: type_length_valid=1.
  - type 0x05DD: type_length_valid=0.
  - Runt frame with 48 body bytes (size 62): packet_size_valid=0.
- Reset mid-frame:
  - Stimulus: assert reset=0 during SRC.
  - Response: flags and counter go to 0 immediately, without waiting for a clock edge.
  - After release, a golden frame → counter=1.

Source files
------------

// File: rtl/epd_pkg.sv
// Shared definitions for the Ethernet packet detector.
//   state_e        : frame-parsing FSM states
//   PREAMBLE_BYTE  : preamble byte value (0x55)
//   SFD_BYTE       : start-of-frame delimiter (0xD5)
//   ETHERTYPE_MIN  : smallest value treated as an EtherType
//   LENGTH_MAX     : largest value treated as a length
//   BROADCAST      : all-ones MAC address
package epd_pkg;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        PRE  = 3'd1,
        DST  = 3'd2,
        SRC  = 3'd3,
        TYPE = 3'd4,
        BODY = 3'd5
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETHERTYPE_MIN = 16'h0600;
    localparam logic [15:0] LENGTH_MAX    = 16'h05DC;
    localparam logic [47:0] BROADCAST     = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/epd.sv
// Ethernet packet detector: passive monitor on a byte-wide MAC receive stream.
// Ports:
//   clock                 in   rising-edge clock
//   reset                 in   asynchronous active-low reset
//   data[7:0]             in   receive byte, sampled every rising edge
//   control               in   1 = frame byte, 0 = idle/IFG byte
//   preamble_valid        out  7x0x55 + 0xD5 seen
//   dst_addr_valid        out  destination is MY_ADDR or broadcast
//   src_addr_valid        out  source is neither all-zero nor broadcast
//   type_length_valid     out  type/length field is legal
//   packet_size_valid     out  frame size in range and all other flags set
//   valid_packet_counter  out  4-bit wrapping count of valid frames
module epd
    import epd_pkg::*;
#(
    parameter logic [47:0] MY_ADDR   = 48'h010203040506,
    parameter int          MIN_FRAME = 64,
    parameter int          MAX_FRAME = 1518
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       control,
    output logic       preamble_valid,
    output logic       dst_addr_valid,
    output logic       src_addr_valid,
    output logic       type_length_valid,
    output logic       packet_size_valid,
    output logic [3:0] valid_packet_counter
);

    state_e      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [2:0]  fld_cnt_q, fld_cnt_d;
    // Only the previous 5 bytes are needed; the 6th comes straight from data.
    logic [39:0] shift_q, shift_d;
    logic [10:0] size_q, size_d;
    logic        pre_ok_q, pre_ok_d;
    logic        dst_ok_q, dst_ok_d;
    logic        src_ok_q, src_ok_d;
    logic        typ_ok_q, typ_ok_d;
    logic        pkt_ok_q, pkt_ok_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [47:0] addr_next;
    logic [15:0] type_next;
    logic [10:0] size_inc;
    logic        frame_ok;

    assign addr_next = {shift_q, data};
    assign type_next = {shift_q[7:0], data};
    assign size_inc  = (size_q == 11'h7FF) ? size_q : size_q + 11'd1;
    assign frame_ok  = (int'(size_q) >= MIN_FRAME) && (int'(size_q) <= MAX_FRAME) &&
                       pre_ok_q && dst_ok_q && src_ok_q && typ_ok_q;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        fld_cnt_d = fld_cnt_q;
        shift_d   = shift_q;
        size_d    = size_q;
        pre_ok_d  = pre_ok_q;
        dst_ok_d  = dst_ok_q;
        src_ok_d  = src_ok_q;
        typ_ok_d  = typ_ok_q;
        pkt_ok_d  = pkt_ok_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            HUNT: begin
                // Flags of the previous frame are dropped only when a new one starts.
                if (control && data == PREAMBLE_BYTE) begin
                    state_d   = PRE;
                    pre_cnt_d = 3'd1;
                    pre_ok_d  = 1'b0;
                    dst_ok_d  = 1'b0;
                    src_ok_d  = 1'b0;
                    typ_ok_d  = 1'b0;
                    pkt_ok_d  = 1'b0;
                end
            end
            PRE: begin
                if (control && data == PREAMBLE_BYTE && pre_cnt_q < 3'd7) begin
                    pre_cnt_d = pre_cnt_q + 3'd1;
                end else if (control && data == SFD_BYTE && pre_cnt_q == 3'd7) begin
                    state_d   = DST;
                    pre_ok_d  = 1'b1;
                    fld_cnt_d = 3'd0;
                    size_d    = 11'd0;
                end else begin
                    state_d = HUNT;
                end
            end
            DST, SRC, TYPE: begin
                if (!control) begin
                    state_d = HUNT;
                end else begin
                    shift_d   = addr_next[39:0];
                    size_d    = size_inc;
                    fld_cnt_d = fld_cnt_q + 3'd1;
                    if (state_q == DST && fld_cnt_q == 3'd5) begin
                        dst_ok_d  = (addr_next == MY_ADDR) || (addr_next == BROADCAST);
                        fld_cnt_d = 3'd0;
                        state_d   = SRC;
                    end else if (state_q == SRC && fld_cnt_q == 3'd5) begin
                        src_ok_d  = (addr_next != 48'd0) && (addr_next != BROADCAST);
                        fld_cnt_d = 3'd0;
                        state_d   = TYPE;
                    end else if (state_q == TYPE && fld_cnt_q == 3'd1) begin
                        typ_ok_d  = (type_next >= ETHERTYPE_MIN) || (type_next <= LENGTH_MAX);
                        fld_cnt_d = 3'd0;
                        state_d   = BODY;
                    end
                end
            end
            BODY: begin
                // Only control=0 ends a frame; control=1 bytes after the CRC extend it.
                if (control) begin
                    size_d = size_inc;
                end else begin
                    pkt_ok_d = frame_ok;
                    if (frame_ok) cnt_d = cnt_q + 4'd1;
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            pre_cnt_q <= 3'd0;
            fld_cnt_q <= 3'd0;
            shift_q   <= 40'd0;
            size_q    <= 11'd0;
            pre_ok_q  <= 1'b0;
            dst_ok_q  <= 1'b0;
            src_ok_q  <= 1'b0;
            typ_ok_q  <= 1'b0;
            pkt_ok_q  <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            fld_cnt_q <= fld_cnt_d;
            shift_q   <= shift_d;
            size_q    <= size_d;
            pre_ok_q  <= pre_ok_d;
            dst_ok_q  <= dst_ok_d;
            src_ok_q  <= src_ok_d;
            typ_ok_q  <= typ_ok_d;
            pkt_ok_q  <= pkt_ok_d;
            cnt_q     <= cnt_d;
        end
    end

    assign preamble_valid       = pre_ok_q;
    assign dst_addr_valid       = dst_ok_q;
    assign src_addr_valid       = src_ok_q;
    assign type_length_valid    = typ_ok_q;
    assign packet_size_valid    = pkt_ok_q;
    assign valid_packet_counter = cnt_q;

endmodule

// File: tb/tb_epd.sv
// Directed bench for epd: a table of frames with hand-computed flags and
// counter, plus hand-written sequences for wrap, merged frames and reset.
module tb_epd;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       control;
    logic       preamble_valid, dst_addr_valid, src_addr_valid;
    logic       type_length_valid, packet_size_valid;
    logic [3:0] valid_packet_counter;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [47:0] GD = 48'h010203040506;
    localparam logic [47:0] GS = 48'hFFFEFDFCFBFA;

    epd dut (
        .clock                (clock),
        .reset                (reset),
        .data                 (data),
        .control              (control),
        .preamble_valid       (preamble_valid),
        .dst_addr_valid       (dst_addr_valid),
        .src_addr_valid       (src_addr_valid),
        .type_length_valid    (type_length_valid),
        .packet_size_valid    (packet_size_valid),
        .valid_packet_counter (valid_packet_counter)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          npre;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        int          body;
        logic [4:0]  flags;   // {pre, dst, src, type, size}
        logic [3:0]  cnt;
    } vec_t;

    vec_t tv[16];

    function automatic logic [4:0] flags_now();
        return {preamble_valid, dst_addr_valid, src_addr_valid,
                type_length_valid, packet_size_valid};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one byte; returns 1 time unit after the sampling edge.
    task automatic send_byte(input logic [7:0] d, input logic c);
        data    = d;
        control = c;
        @(posedge clock);
        #1;
    endtask

    // npre x 0x55, SFD, DST, SRC, type, (body-1) x 0x55 + 0xFF, optional IFG byte.
    task automatic send_frame(input int npre, input logic [47:0] dst,
                              input logic [47:0] src, input logic [15:0] typ,
                              input int body, input bit ifg);
        logic [47:0] a;
        for (int i = 0; i < npre; i++) send_byte(8'h55, 1'b1);
        send_byte(8'hD5, 1'b1);
        a = dst;
        for (int i = 5; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
        a = src;
        for (int i = 5; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
        send_byte(typ[15:8], 1'b1);
        send_byte(typ[7:0], 1'b1);
        for (int i = 0; i < body - 1; i++) send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1);
        if (ifg) send_byte(8'h00, 1'b0);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        data    = 8'h00;
        control = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // golden 64-byte frames and field variations; cnt is cumulative
        tv[0]  = '{7, GD, GS, 16'h0800, 50,   5'b11111, 4'd1};
        tv[1]  = '{7, GD, GS, 16'h0800, 50,   5'b11111, 4'd2};
        tv[2]  = '{7, 48'h010203040507, GS, 16'h0800, 50, 5'b10110, 4'd2};
        tv[3]  = '{7, GD, 48'd0, 16'h0800, 50, 5'b11010, 4'd2};
        tv[4]  = '{7, GD, 48'hFFFF_FFFF_FFFF, 16'h0800, 50, 5'b11010, 4'd2};
        tv[5]  = '{7, 48'hFFFF_FFFF_FFFF, GS, 16'h0800, 50, 5'b11111, 4'd3};
        tv[6]  = '{7, GD, GS, 16'h0600, 50,   5'b11111, 4'd4};
        tv[7]  = '{7, GD, GS, 16'h05DD, 50,   5'b11100, 4'd4};
        tv[8]  = '{7, GD, GS, 16'h05DC, 50,   5'b11111, 4'd5};
        tv[9]  = '{7, GD, GS, 16'h05FF, 50,   5'b11100, 4'd5};
        tv[10] = '{7, GD, GS, 16'h0800, 48,   5'b11110, 4'd5};  // size 62
        tv[11] = '{7, GD, GS, 16'h0800, 1504, 5'b11111, 4'd6};  // size 1518
        tv[12] = '{7, GD, GS, 16'h0800, 1505, 5'b11110, 4'd6};  // size 1519
        tv[13] = '{6, GD, GS, 16'h0800, 50,   5'b00000, 4'd6};  // short preamble
        tv[14] = '{8, GD, GS, 16'h0800, 50,   5'b00000, 4'd6};  // extra 0x55
        tv[15] = '{7, GD, GS, 16'h0800, 49,   5'b11110, 4'd6};  // size 63

        do_reset();
        check("reset_flags", int'(flags_now()), 0);
        check("reset_cnt", int'(valid_packet_counter), 0);

        for (int k = 0; k < 16; k++) begin
            send_frame(tv[k].npre, tv[k].dst, tv[k].src, tv[k].typ, tv[k].body, 1'b1);
            check($sformatf("vec%0d_flags", k), int'(flags_now()), int'(tv[k].flags));
            check($sformatf("vec%0d_cnt", k), int'(valid_packet_counter), int'(tv[k].cnt));
        end

        // preamble flag is visible right after the SFD edge
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b1);
        check("pre_before_sfd", int'(preamble_valid), 0);
        send_byte(8'hD5, 1'b1);
        check("pre_after_sfd", int'(preamble_valid), 1);
        send_byte(8'h00, 1'b0);  // abort in DST
        check("abort_dst_cnt", int'(valid_packet_counter), 6);

        // counter wrap over 16 frames
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            send_frame(7, GD, GS, 16'h0800, 50, 1'b1);
            check($sformatf("wrap%0d_cnt", k), int'(valid_packet_counter), k % 16);
        end

        // control-high IFG merges frames 2 and 3 into one 139-byte frame
        do_reset();
        send_frame(7, GD, GS, 16'h0800, 50, 1'b1);
        check("merge_f1_cnt", int'(valid_packet_counter), 1);
        send_frame(7, GD, GS, 16'h0800, 50, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        send_frame(7, GD, GS, 16'h0800, 50, 1'b1);
        check("merge_f23_cnt", int'(valid_packet_counter), 2);
        check("merge_f23_flags", int'(flags_now()), 5'b11111);
        send_frame(7, GD, GS, 16'h0800, 50, 1'b1);
        check("merge_f4_cnt", int'(valid_packet_counter), 3);

        // asynchronous reset in the middle of SRC
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b1);
        send_byte(8'hD5, 1'b1);
        for (int i = 5; i >= 0; i--) send_byte(GD[i*8 +: 8], 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'hF0, 1'b1);
        check("midreset_pre_flags", int'(flags_now()), 5'b11000);
        #1;
        reset   = 1'b0;
        control = 1'b0;
        #1;
        check("midreset_flags", int'(flags_now()), 0);
        check("midreset_cnt", int'(valid_packet_counter), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        send_byte(8'h00, 1'b0);
        send_frame(7, GD, GS, 16'h0800, 50, 1'b1);
        check("postreset_cnt", int'(valid_packet_counter), 1);
        check("postreset_flags", int'(flags_now()), 5'b11111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
